// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel pacer.
package vga_pkg;

  typedef enum logic [1:0] {
    RESYNC   = 2'd0,
    WAIT_SOF = 2'd1,
    STREAM   = 2'd2
  } pacer_state_e;

  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
  localparam int          STAT_W         = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/vga_pacer_head.sv
// One-word head register with a ready/pop handshake; usable as a generic skid stage.
// 'keep' selects whether an accepted word is stored or discarded, 'flush' empties the stage.
module vga_pacer_head #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         keep,
  input  logic         pop,
  input  logic         flush,
  output logic         head_valid,
  output logic [W-1:0] head_data
);

  logic accept;

  // Pop and refill in the same cycle keeps one word per cycle of throughput.
  assign s_ready = !head_valid || pop;
  assign accept  = s_valid && s_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  // NOTE: the data word is reset too; it is a single register, not a memory array,
  // so the reset costs nothing and keeps the outputs deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (accept && keep) begin
      head_valid <= 1'b1;
      head_data  <= s_data;
    end else if (pop || flush) begin
      head_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_pixel_pacer.sv
// Pixel-clock pacer: releases one RGB565 word per active-video cycle with registered syncs,
// and resynchronises to the next start of frame on underflow or misalignment. Stats: VGA_PACER_STATS_EN.
module vga_pixel_pacer
  import vga_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    H_ACTIVE        = 640,
  parameter int                    V_ACTIVE        = 480,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = RGB565_MAGENTA
) (
  input  logic                  pix_clk,
  input  logic                  pix_rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  input  logic                  de_in,
  input  logic                  hs_in,
  input  logic                  vs_in,
  input  logic                  frame_start,
  output logic [4:0]            vga_red,
  output logic [5:0]            vga_green,
  output logic [4:0]            vga_blue,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic                  err_underflow,
  output logic                  err_align,
  output logic [STAT_W-1:0]     stat_underflow_cnt,
  output logic [STAT_W-1:0]     stat_resync_cnt
);

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int HW  = DATA_WIDTH + 2;

  pacer_state_e          state, state_nxt;
  logic [X_W-1:0]        x_cnt;
  logic [Y_W-1:0]        y_cnt;
  logic                  uf_pending;

  logic                  head_valid;
  logic [HW-1:0]         head_word;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_sof, head_eol;

  logic                  accept, keep, flush, pop;
  logic                  active_stream, underflow, align_err;
  logic                  x_last, y_last, at_origin, frame_end, leave;
  logic [DATA_WIDTH-1:0] pix_q;

  vga_pacer_head #(.W(HW)) u_head (
    .clk        (pix_clk),
    .rst        (pix_rst),
    .s_valid    (s_tvalid),
    .s_ready    (s_tready),
    .s_data     ({s_tuser, s_tlast, s_tdata}),
    .keep       (keep),
    .pop        (pop),
    .flush      (flush),
    .head_valid (head_valid),
    .head_data  (head_word)
  );

  assign {head_sof, head_eol, head_data} = head_word;
  assign accept = s_tvalid && s_tready;

  always_comb begin
    x_last        = (x_cnt == X_W'(H_ACTIVE - 1));
    y_last        = (y_cnt == Y_W'(V_ACTIVE - 1));
    at_origin     = (x_cnt == '0) && (y_cnt == '0);
    active_stream = (state == STREAM) && de_in;
    pop           = active_stream && head_valid;
    underflow     = active_stream && !head_valid;
    align_err     = pop && ((head_eol != x_last) || (head_sof != at_origin));
    frame_end     = active_stream && x_last && y_last;
    // Misalignment leaves immediately; an underflowed frame is finished first.
    leave         = align_err || (frame_end && (uf_pending || underflow));
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    keep      = 1'b1;
    flush     = 1'b0;
    unique case (state)
      RESYNC: begin
        keep = s_tuser;
        // A sof word may already be held from the cycle that left STREAM.
        if (head_valid || (accept && s_tuser)) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (frame_start) state_nxt = STREAM;
      end
      STREAM: begin
        if (leave) begin
          state_nxt = RESYNC;
          flush     = 1'b1;
          keep      = s_tuser;
        end
      end
      default: state_nxt = RESYNC;
    endcase
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) state <= RESYNC;
    else         state <= state_nxt;
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if ((state == WAIT_SOF) && frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (active_stream) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_cnt + Y_W'(1);
      end else begin
        x_cnt <= x_cnt + X_W'(1);
      end
    end
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      uf_pending    <= 1'b0;
      err_underflow <= 1'b0;
      err_align     <= 1'b0;
    end else begin
      uf_pending    <= (state == STREAM) && (uf_pending || underflow);
      err_underflow <= err_underflow || underflow;
      err_align     <= err_align || align_err;
    end
  end

  // All pin outputs share one register stage so they stay aligned.
  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      vga_de <= 1'b0;
      vga_hs <= 1'b0;
      vga_vs <= 1'b0;
      pix_q  <= '0;
    end else begin
      vga_de <= de_in;
      vga_hs <= hs_in;
      vga_vs <= vs_in;
      if (!de_in)   pix_q <= '0;
      else if (pop) pix_q <= head_data;
      else          pix_q <= UNDERFLOW_COLOR;
    end
  end

  assign vga_red   = pix_q[15:11];
  assign vga_green = pix_q[10:5];
  assign vga_blue  = pix_q[4:0];

`ifdef VGA_PACER_STATS_EN
  logic [STAT_W-1:0] uf_cnt_q, rs_cnt_q;

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      uf_cnt_q <= '0;
      rs_cnt_q <= '0;
    end else begin
      if (underflow)                    uf_cnt_q <= sat_inc(uf_cnt_q);
      if ((state == STREAM) && leave)   rs_cnt_q <= sat_inc(rs_cnt_q);
    end
  end

  assign stat_underflow_cnt = uf_cnt_q;
  assign stat_resync_cnt    = rs_cnt_q;
`else
  assign stat_underflow_cnt = '0;
  assign stat_resync_cnt    = '0;
`endif

endmodule
